mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 ADDR_W, 11, data-memory word-address width; fixed, not overridable.
REQ-002 DATA_W, 32, data-memory word width; fixed, not overridable.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; rst=0 forces reset state immediately.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  11  first word address of the load; sampled with start.
REQ-007 word_cnt  input  11  number of 32-bit words to load; sampled with start.
REQ-008 abort  input  1  cancel the current load; honoured in any state.
REQ-009 in_valid  input  1  host byte available on in_byte.
REQ-010 in_byte  input  8  host data byte.
REQ-011 in_ready  output  1  loader accepts a byte this cycle.
REQ-012 hld  output  1  processor hold; steers the data-memory address mux to mem_addr.
REQ-013 mem_en  output  1  data-memory enable.
REQ-014 mem_we  output  1  data-memory write enable.
REQ-015 mem_addr  output  11  data-memory word address.
REQ-016 mem_din  output  32  data-memory write data.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse: load completed normally.

Function
REQ-019 FSM states SHALL be exactly IDLE, COLLECT, WRITE, DONE.
REQ-020 IDLE: start=1 and word_cnt!=0 -> latch base_addr into addr register, word_cnt into remaining counter, clear byte index and shift register; next state COLLECT.
REQ-021 IDLE: start=1 and word_cnt=0 -> no memory access; next state DONE.
REQ-022 in_ready SHALL equal 1 only in COLLECT; a byte transfers on a rising edge with in_valid=1 and in_ready=1.
REQ-023 Byte order SHALL be big-endian: 1st byte -> bits [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-024 The 2-bit byte index SHALL increment per transfer; the 4th transfer moves COLLECT -> WRITE and resets the index to 0.
REQ-025 in_valid=0 in COLLECT SHALL hold all state; no timeout.
REQ-026 WRITE lasts exactly one cycle: mem_en=1, mem_we=1, mem_addr=addr register, mem_din=assembled word; memory captures on the falling clk edge inside this cycle.
REQ-027 Leaving WRITE: addr register increments modulo 2048 (2047 wraps to 0); remaining decrements; remaining was 1 -> DONE, else COLLECT.
REQ-028 DONE lasts one cycle with done=1, hld=1, mem_en=0; next state IDLE.
REQ-029 hld SHALL be 1 in COLLECT, WRITE and DONE; 0 in IDLE.
REQ-030 mem_en=mem_we=0 and mem_din=0 outside WRITE; mem_addr SHALL always show the addr register.
REQ-031 abort=1 on a rising edge SHALL force IDLE from any state; a partially assembled word is discarded, no write occurs, and done is not pulsed.
REQ-032 abort takes priority over start, over a byte transfer, and over the WRITE-cycle write: abort during WRITE suppresses mem_we combinationally in that cycle.
REQ-033 start while busy=1 SHALL be ignored and SHALL NOT alter latched parameters.
REQ-034 Minimum load time for N words SHALL be 5N+1 cycles from the start edge to the done pulse; maximum throughput is 1 byte per cycle in COLLECT.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, addr register=0, remaining=0, byte index=0, shift register=0.
REQ-036 During reset all outputs SHALL be 0: in_ready, hld, mem_en, mem_we, mem_addr, mem_din, busy, done.
REQ-037 Reset asserted mid-load SHALL abandon the load without a write; after release the block waits in IDLE for a new start.

Verification
REQ-038 start, base_addr=0x010, word_cnt=2, bytes 11 22 33 44 55 66 77 88 sent back-to-back -> writes 0x11223344 @0x010, 0x55667788 @0x011; done at cycle 11 after start.
REQ-039 base_addr=0x7FF, word_cnt=2 -> writes at 0x7FF then 0x000.
REQ-040 word_cnt=0 -> no mem_we; done one cycle after start; hld high only in the DONE cycle.
REQ-041 abort after 2 bytes of word 1 -> IDLE next cycle, hld=0, no mem_we, no done.
REQ-042 rst=0 asserted while in WRITE -> mem_we=0 immediately, all outputs 0; the memory word is unchanged.
REQ-043 in_valid toggled 1/0 every cycle, start repeated while busy -> same data and addresses as with back-to-back bytes; the repeated start has no effect.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: collects host bytes, packs them big-endian into 32-bit words and
// writes them to consecutive data-memory word addresses while holding the
// processor off the memory bus.
//
// Handshake: a host byte moves on a rising clk edge when in_valid and in_ready
// are both 1; in_ready is high only while collecting, and the host may hold
// in_valid low for any number of cycles without the loader giving up.
module mem_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] base_addr,
  input  logic [10:0] word_cnt,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        hld,
  output logic        mem_en,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_remaining;
  logic [1:0]          r_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                w_xfer;

  // A byte transfers whenever the loader is collecting and the host offers one.
  assign w_xfer = (r_state == ST_COLLECT) && in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all outputs; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    hld         = 1'b1;
    busy        = 1'b1;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_din     = '0;
    done        = 1'b0;
    mem_addr    = r_addr;
    dbg_state   = r_state;
    case (r_state)
      ST_IDLE: begin
        hld  = 1'b0;
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (word_cnt == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        in_ready = 1'b1;
        if (w_xfer && (r_idx == 2'd3)) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_en  = 1'b1;
        // An abort in this cycle must keep the word out of memory.
        mem_we  = !abort;
        mem_din = r_shift;
        w_state_nxt = (r_remaining == 11'd1) ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Load parameters, byte assembly and address/count stepping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
    end else if (abort) begin
      // Drop any partially assembled word; the next start re-latches the rest.
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && (word_cnt != '0)) begin
            r_addr      <= base_addr;
            r_remaining <= word_cnt;
            r_idx       <= '0;
            r_shift     <= '0;
          end
        end
        ST_COLLECT: begin
          if (w_xfer) begin
            // Shifting left makes the first byte of a word land in [31:24].
            r_shift <= {r_shift[DATA_W-9:0], in_byte};
            // The 2-bit index wraps to 0 on the fourth byte.
            r_idx   <= r_idx + 2'd1;
          end
        end
        ST_WRITE: begin
          // Address wraps naturally at the 11-bit boundary (2047 -> 0).
          r_addr      <= r_addr + 11'd1;
          r_remaining <= r_remaining - 11'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed and randomized loads; expected memory writes and done
// pulses are queued by the stimulus side and consumed by a negedge monitor.
module tb_mem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] word_cnt;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        hld;
  logic        mem_en;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_din;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .hld       (hld),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [42:0] exp_q[$];   // {addr, data} of each expected write
  int          done_q[$];  // expected start-to-done edge count, -1 = any
  logic [31:0] mem_model [2048];
  logic [7:0]  byte_buf [32];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          start_cyc = 0;
  logic [42:0] mon_e;
  int          mon_lat;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail_evt(string name);
    n_checks++;
    $display("FAIL %s: got 1 expected 0", name);
  endfunction

  // ---------------- monitor ----------------
  // Memory captures on the falling edge, so that is where writes are observed.
  always @(negedge clk) begin
    if (mem_en && mem_we) begin
      mem_model[mem_addr] = mem_din;
      if (exp_q.size() == 0) begin
        fail_evt("unexpected write");
      end else begin
        mon_e = exp_q.pop_front();
        chk("write addr", 64'(mem_addr), 64'(mon_e[42:32]));
        chk("write data", 64'(mem_din), 64'(mon_e[31:0]));
      end
    end
    if (!mem_en) chk("bus quiet", {mem_we, mem_din}, '0);
    if (done) begin
      if (done_q.size() == 0) begin
        fail_evt("unexpected done");
      end else begin
        mon_lat = done_q.pop_front();
        // Done is seen after 5N edges past the start edge (5N+1 cycles
        // counting the start cycle itself).
        if (mon_lat >= 0) chk("done latency", 64'(cyc - start_cyc), 64'(mon_lat));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers run at posedge+1 and leave time at posedge+1.
  task automatic do_start(input logic [10:0] b, input logic [10:0] n);
    start = 1'b1; base_addr = b; word_cnt = n;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // One load of n words from byte_buf. gap: idle cycle after each byte with a
  // junk start. abort_after: bytes sent before abort is raised (-1 = none).
  task automatic load(input logic [10:0] b, input int n, input bit gap,
                      input int abort_after);
    logic [31:0] w;
    bit ab;
    int tmo;
    w = '0;
    ab = (abort_after >= 0) && (n >= 1) &&
         ((abort_after < 4*n) || ((abort_after == 4*n) && !gap));
    if (!ab) done_q.push_back(gap ? -1 : 5*n);
    do_start(b, 11'(n));
    for (int i = 0; i < 4*n; i++) begin
      if (ab && i == abort_after) break;
      tmo = 0;
      while (!in_ready && tmo < 8) begin @(posedge clk); #1; tmo++; end
      if (!in_ready) begin fail_evt("in_ready timeout"); break; end
      in_valid = 1'b1; in_byte = byte_buf[i];
      w = {w[23:0], byte_buf[i]};
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Back-to-back, an abort right after a word's 4th byte lands in its
      // write cycle and cancels that write.
      if ((i % 4 == 3) && !(ab && !gap && abort_after == i + 1))
        exp_q.push_back({b + 11'(i / 4), w});
      if (gap) begin
        if (i < 4*n - 1) begin
          start = 1'b1; base_addr = 11'($urandom); word_cnt = 11'($urandom_range(1, 5));
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    if (ab) begin
      abort = 1'b1; in_valid = 1'b1; in_byte = 8'hEE;
      #1 chk("mem_we under abort", 64'(mem_we), 64'd0);
      @(posedge clk); #1;
      abort = 1'b0; in_valid = 1'b0;
      chk("busy after abort", 64'(busy), 64'd0);
      chk("hld after abort", 64'(hld), 64'd0);
    end else begin
      tmo = 0;
      while (busy && tmo < 16) begin @(posedge clk); #1; tmo++; end
      chk("load finished", 64'(busy), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int aa;
    bit g;
    for (int i = 0; i < 2048; i++) mem_model[i] = '0;
    rst = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
    abort = 1'b0; in_valid = 1'b0; in_byte = '0;
    #2;
    chk("reset outputs", {in_ready, hld, mem_en, mem_we, mem_addr, mem_din, busy, done}, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", {hld, busy, in_ready}, '0);

    // Two words back-to-back at 0x010.
    for (int i = 0; i < 8; i++) byte_buf[i] = 8'(8'h11 * (i + 1));
    load(11'h010, 2, 1'b0, -1);

    // Address wrap 0x7FF -> 0x000.
    for (int i = 0; i < 8; i++) byte_buf[i] = 8'($urandom);
    load(11'h7FF, 2, 1'b0, -1);

    // Zero-word load: done next cycle, hld only during that cycle.
    done_q.push_back(0);
    do_start(11'h055, 11'd0);
    chk("zero load hld/done", {hld, done}, 2'b11);
    @(posedge clk); #1;
    chk("zero load after", {hld, busy}, 2'b00);

    // Abort after two bytes of the first word.
    for (int i = 0; i < 8; i++) byte_buf[i] = 8'($urandom);
    load(11'h200, 2, 1'b0, 2);

    // Abort during the write cycle of the only word.
    load(11'h210, 1, 1'b0, 4);

    // Throttled host with starts repeated while busy: same result as 0x010 load.
    for (int i = 0; i < 8; i++) byte_buf[i] = 8'(8'h11 * (i + 1));
    load(11'h010, 2, 1'b1, -1);

    // Reset asserted inside the write cycle.
    for (int i = 0; i < 4; i++) byte_buf[i] = 8'($urandom_range(1, 255));
    do_start(11'h123, 11'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_byte = byte_buf[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mem_we in write", 64'(mem_we), 64'd1);
    rst = 1'b0;
    #1;
    chk("outputs under reset", {in_ready, hld, mem_en, mem_we, mem_addr, mem_din, busy, done}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("idle after mid-load reset", 64'(busy), 64'd0);
    chk("word untouched", 64'(mem_model[11'h123]), 64'd0);

    // Randomized loads, some throttled, some aborted.
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 4);
      g = 1'($urandom_range(0, 1));
      aa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4*n) : -1;
      for (int i = 0; i < 32; i++) byte_buf[i] = 8'($urandom);
      load(11'($urandom), n, g, aa);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("pending writes", 64'(exp_q.size()), 64'd0);
    chk("pending done", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
